// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds the FSM state encoding, the opcode map, the ALUOp / BorN codes
// driven onto the ALU interface and the PC source select encodings.
package mc_ctrl_pkg;

    localparam int OPC_W   = 6;
    localparam int FUNCT_W = 3;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM, WB, BRANCH, JUMP, TRAP
    } state_t;

    // Opcodes (Instr[31:26])
    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_BLT   = 6'h06;
    localparam logic [OPC_W-1:0] OP_BLE   = 6'h07;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    // ALUOp codes
    localparam logic [2:0] ALU_MOV = 3'd0;
    localparam logic [2:0] ALU_NOT = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_AND = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    // BorN codes (equal to opcode[1:0] of the branch opcodes)
    localparam logic [1:0] BR_BEQ = 2'd0;
    localparam logic [1:0] BR_BNE = 2'd1;
    localparam logic [1:0] BR_BLT = 2'd2;
    localparam logic [1:0] BR_BLE = 2'd3;

    // PC source select
    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    // BEQ/BNE/BLT/BLE occupy opcodes 0x04..0x07
    function automatic logic is_branch(input logic [OPC_W-1:0] op);
        return op[OPC_W-1:2] == 4'b0001;
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU control decode for the multi-cycle control unit.
// Ports:
//   state     in  current FSM state
//   opcode    in  Instr[31:26]
//   funct     in  Instr[2:0] (R-type function, maps 1:1 onto ALUOp)
//   alu_op    out ALU operation select
//   born      out branch compare select
//   alu_src_b out 0 register B, 1 sign-extended immediate
module alu_op_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W_P   = OPC_W,
    parameter int FUNCT_W_P = FUNCT_W
) (
    input  state_t               state,
    input  logic [OPC_W_P-1:0]   opcode,
    input  logic [FUNCT_W_P-1:0] funct,
    output logic [2:0]           alu_op,
    output logic [1:0]           born,
    output logic                 alu_src_b
);

    always_comb begin
        alu_op    = ALU_MOV;
        born      = BR_BEQ;
        alu_src_b = 1'b0;
        case (state)
            EXEC_R: alu_op = funct;
            EXEC_I: begin
                alu_op    = ALU_ADD;
                alu_src_b = 1'b1;
            end
            BRANCH: begin
                // compare is done as B-A; branch kind is the low opcode bits
                alu_op = ALU_SUB;
                born   = opcode[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the bare 32-bit MIPS core.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives the ALU control
// (ALUOp, BorN, ALU_Src_B), the PC/IR/register-file/memory strobes, and
// waits on Mem_Ready for every memory access.
// Ports:
//   Clock, Reset_n (async active-low)
//   Instr, Branch_Flag, Mem_Ready                         inputs
//   ALUOp, BorN, ALU_Src_B, PC_Write, PC_Src, IR_Write,
//   Mem_Read, Mem_Write, Reg_Write, Reg_Dst, Mem_To_Reg,
//   Illegal_Op                                            outputs
// Configuration:
//   ILLEGAL_OP_TRAP_EN  unknown opcodes enter a sticky TRAP state and raise
//                       Illegal_Op; otherwise they execute as a NOP.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W_P   = OPC_W,
    parameter int FUNCT_W_P = FUNCT_W
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] Instr,
    input  logic        Branch_Flag,
    input  logic        Mem_Ready,
    output logic [2:0]  ALUOp,
    output logic [1:0]  BorN,
    output logic        ALU_Src_B,
    output logic        PC_Write,
    output logic [1:0]  PC_Src,
    output logic        IR_Write,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        Reg_Write,
    output logic        Reg_Dst,
    output logic        Mem_To_Reg,
    output logic        Illegal_Op
);

    state_t state, state_next;

    logic [OPC_W_P-1:0]   opcode;
    logic [FUNCT_W_P-1:0] funct;
    logic                 unused_instr;
    assign opcode       = Instr[31 -: OPC_W_P];
    assign funct        = Instr[FUNCT_W_P-1:0];
    assign unused_instr = ^Instr[31-OPC_W_P:FUNCT_W_P];

    logic [2:0] alu_op;
    logic [1:0] born;
    logic       alu_src_b;

    alu_op_decoder #(.OPC_W_P(OPC_W_P), .FUNCT_W_P(FUNCT_W_P)) u_alu_dec (
        .state     (state),
        .opcode    (opcode),
        .funct     (funct),
        .alu_op    (alu_op),
        .born      (born),
        .alu_src_b (alu_src_b)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= FETCH;
        else          state <= state_next;
    end

    logic       pc_write, ir_write, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal;
    logic [1:0] pc_src;

    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                mem_read = 1'b1;
                if (Mem_Ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (opcode == OP_RTYPE)
                    state_next = EXEC_R;
                else if (opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW)
                    state_next = EXEC_I;
                else if (is_branch(opcode))
                    state_next = BRANCH;
                else if (opcode == OP_J)
                    state_next = JUMP;
                else
`ifdef ILLEGAL_OP_TRAP_EN
                    state_next = TRAP;
`else
                    state_next = FETCH;
`endif
            end
            EXEC_R: state_next = WB;
            EXEC_I: state_next = (opcode == OP_ADDI) ? WB : MEM;
            MEM: begin
                mem_read  = (opcode == OP_LW);
                mem_write = (opcode == OP_SW);
                if (Mem_Ready) state_next = (opcode == OP_LW) ? WB : FETCH;
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                mem_to_reg = (opcode == OP_LW);
                state_next = FETCH;
            end
            BRANCH: begin
                pc_src     = PC_SRC_BR;
                pc_write   = Branch_Flag;
                state_next = FETCH;
            end
            JUMP: begin
                pc_src     = PC_SRC_JMP;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            TRAP: begin
                // held here until Reset_n; state itself makes the flag sticky
                illegal    = 1'b1;
                state_next = TRAP;
            end
            default: state_next = FETCH;
        endcase
    end

    // While reset is asserted every output reads 0, including the FETCH
    // read request, so nothing leaks to memory during reset.
    assign ALUOp      = Reset_n ? alu_op    : ALU_MOV;
    assign BorN       = Reset_n ? born      : BR_BEQ;
    assign ALU_Src_B  = Reset_n & alu_src_b;
    assign PC_Write   = Reset_n & pc_write;
    assign PC_Src     = Reset_n ? pc_src    : PC_SRC_SEQ;
    assign IR_Write   = Reset_n & ir_write;
    assign Mem_Read   = Reset_n & mem_read;
    assign Mem_Write  = Reset_n & mem_write;
    assign Reg_Write  = Reset_n & reg_write;
    assign Reg_Dst    = Reset_n & reg_dst;
    assign Mem_To_Reg = Reset_n & mem_to_reg;
`ifdef ILLEGAL_OP_TRAP_EN
    assign Illegal_Op = Reset_n & illegal;
`else
    assign Illegal_Op = 1'b0;
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: each driven cycle pushes the
// expected output vector; a negedge monitor pops and compares.
module tb_mc_control_unit;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] Instr = 32'h0;
    logic        Branch_Flag = 1'b0;
    logic        Mem_Ready = 1'b0;
    logic [2:0]  ALUOp;
    logic [1:0]  BorN;
    logic        ALU_Src_B, PC_Write, IR_Write, Mem_Read, Mem_Write;
    logic        Reg_Write, Reg_Dst, Mem_To_Reg, Illegal_Op;
    logic [1:0]  PC_Src;

    mc_control_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .Instr(Instr),
        .Branch_Flag(Branch_Flag), .Mem_Ready(Mem_Ready),
        .ALUOp(ALUOp), .BorN(BorN), .ALU_Src_B(ALU_Src_B),
        .PC_Write(PC_Write), .PC_Src(PC_Src), .IR_Write(IR_Write),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Reg_Write(Reg_Write),
        .Reg_Dst(Reg_Dst), .Mem_To_Reg(Mem_To_Reg), .Illegal_Op(Illegal_Op)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       nm;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    // {ALUOp,BorN,Src_B,PC_Write,PC_Src,IR_Write,Mem_Read,Mem_Write,Reg_Write,Reg_Dst,Mem_To_Reg,Illegal_Op}
    function automatic logic [15:0] ev(input logic [2:0] alu, input logic [1:0] bn,
                                       input logic sb, input logic pcw, input logic [1:0] pcs,
                                       input logic irw, input logic mr, input logic mw,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic il);
        return {alu, bn, sb, pcw, pcs, irw, mr, mw, rw, rd, m2r, il};
    endfunction

    function automatic logic [15:0] act_vec();
        return {ALUOp, BorN, ALU_Src_B, PC_Write, PC_Src, IR_Write, Mem_Read,
                Mem_Write, Reg_Write, Reg_Dst, Mem_To_Reg, Illegal_Op};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor
    always @(negedge Clock) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk(cur.nm, act_vec(), cur.v);
        end
    end

    task automatic step(input string nm, input logic [31:0] ins, input logic rdy,
                        input logic bf, input logic [15:0] e);
        Instr       = ins;
        Mem_Ready   = rdy;
        Branch_Flag = bf;
        q.push_back('{nm, e});
        @(posedge Clock);
        #1;
    endtask

    logic [15:0] V_F, V_FW, V_Z;
    logic [31:0] I_ADD, I_LW, I_BNE, I_SW, I_ADDI, I_J, I_BLE, I_BAD, I_AND;

    initial begin
        V_F  = ev(3'd0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_FW = ev(3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        V_Z  = 16'h0;
        I_ADD  = {6'h00, 5'd1, 5'd2, 5'd3, 8'h00, 3'd2};
        I_AND  = {6'h00, 5'd1, 5'd2, 5'd3, 8'h00, 3'd5};
        I_LW   = {6'h23, 5'd1, 5'd2, 16'h0010};
        I_BNE  = {6'h05, 5'd1, 5'd2, 16'hfffc};
        I_BLE  = {6'h07, 5'd1, 5'd2, 16'h0008};
        I_SW   = {6'h2B, 5'd1, 5'd2, 16'h0004};
        I_ADDI = {6'h08, 5'd1, 5'd2, 16'h8001};
        I_J    = {6'h02, 26'h0000100};
        I_BAD  = {6'h3F, 26'h0};

        // reset state, with Mem_Ready high to show it is ignored
        Mem_Ready = 1'b1;
        #2;
        chk("reset_outputs", act_vec(), V_Z);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;

        // 1. ADD R-type, 4 cycles
        step("add_fetch",  I_ADD, 1'b1, 1'b0, V_F);
        step("add_decode", I_ADD, 1'b1, 1'b0, V_Z);
        step("add_exec",   I_ADD, 1'b1, 1'b0, ev(3'd2,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step("add_wb",     I_ADD, 1'b1, 1'b0, ev(3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0));

        // R-type AND with a fetch wait cycle
        step("and_fetch_wait", I_AND, 1'b0, 1'b0, V_FW);
        step("and_fetch",      I_AND, 1'b1, 1'b0, V_F);
        step("and_decode",     I_AND, 1'b0, 1'b0, V_Z);
        step("and_exec",       I_AND, 1'b0, 1'b0, ev(3'd5,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step("and_wb",         I_AND, 1'b0, 1'b0, ev(3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0));

        // 2. LW with two wait cycles in MEM, 7 cycles
        step("lw_fetch",  I_LW, 1'b1, 1'b0, V_F);
        step("lw_decode", I_LW, 1'b1, 1'b0, V_Z);
        step("lw_exec",   I_LW, 1'b1, 1'b0, ev(3'd2,2'd0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step("lw_mem_w1", I_LW, 1'b0, 1'b0, V_FW);
        step("lw_mem_w2", I_LW, 1'b0, 1'b0, V_FW);
        step("lw_mem",    I_LW, 1'b1, 1'b0, V_FW);
        step("lw_wb",     I_LW, 1'b1, 1'b0, ev(3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0));

        // 3. BNE taken then not taken
        step("bne_t_fetch",  I_BNE, 1'b1, 1'b0, V_F);
        step("bne_t_decode", I_BNE, 1'b1, 1'b1, V_Z);
        step("bne_t_branch", I_BNE, 1'b1, 1'b1, ev(3'd3,2'd1,1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step("bne_n_fetch",  I_BNE, 1'b1, 1'b0, V_F);
        step("bne_n_decode", I_BNE, 1'b1, 1'b0, V_Z);
        step("bne_n_branch", I_BNE, 1'b1, 1'b0, ev(3'd3,2'd1,1'b0,1'b0,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        // BLE taken
        step("ble_fetch",  I_BLE, 1'b1, 1'b0, V_F);
        step("ble_decode", I_BLE, 1'b1, 1'b0, V_Z);
        step("ble_branch", I_BLE, 1'b1, 1'b1, ev(3'd3,2'd3,1'b0,1'b1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));

        // 4. SW, zero wait, 4 cycles
        step("sw_fetch",  I_SW, 1'b1, 1'b0, V_F);
        step("sw_decode", I_SW, 1'b1, 1'b0, V_Z);
        step("sw_exec",   I_SW, 1'b1, 1'b0, ev(3'd2,2'd0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step("sw_mem",    I_SW, 1'b1, 1'b0, ev(3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0));

        // ADDI, 4 cycles, writes rt
        step("addi_fetch",  I_ADDI, 1'b1, 1'b0, V_F);
        step("addi_decode", I_ADDI, 1'b1, 1'b0, V_Z);
        step("addi_exec",   I_ADDI, 1'b1, 1'b0, ev(3'd2,2'd0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step("addi_wb",     I_ADDI, 1'b1, 1'b0, ev(3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));

        // J, 3 cycles
        step("j_fetch",  I_J, 1'b1, 1'b0, V_F);
        step("j_decode", I_J, 1'b1, 1'b0, V_Z);
        step("j_jump",   I_J, 1'b1, 1'b0, ev(3'd0,2'd0,1'b0,1'b1,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));

        // 5. reset pulsed during MEM of SW
        step("swr_fetch",  I_SW, 1'b1, 1'b0, V_F);
        step("swr_decode", I_SW, 1'b1, 1'b0, V_Z);
        step("swr_exec",   I_SW, 1'b1, 1'b0, ev(3'd2,2'd0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        Instr = I_SW;
        Mem_Ready = 1'b0;
        q.push_back('{"swr_mem", ev(3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0)});
        @(negedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("swr_async_reset", act_vec(), V_Z);
        @(posedge Clock);
        #1;
        chk("swr_held_reset", act_vec(), V_Z);
        Reset_n = 1'b1;
        step("swr_restart_fetch", I_ADD, 1'b1, 1'b0, V_F);
        step("swr_restart_decode", I_ADD, 1'b1, 1'b0, V_Z);
        step("swr_restart_exec", I_ADD, 1'b1, 1'b0, ev(3'd2,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step("swr_restart_wb", I_ADD, 1'b1, 1'b0, ev(3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0));

        // 6. illegal opcode 0x3F
        step("bad_fetch",  I_BAD, 1'b1, 1'b0, V_F);
        step("bad_decode", I_BAD, 1'b1, 1'b0, V_Z);
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 3; i++)
            step("bad_trap", I_ADD, 1'b1, 1'b1, ev(3'd0,2'd0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1));
        @(negedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("bad_trap_reset", act_vec(), V_Z);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        step("bad_after_reset", I_ADD, 1'b1, 1'b0, V_F);
`else
        step("bad_nop_fetch", I_ADD, 1'b1, 1'b0, V_F);
        step("bad_nop_decode", I_ADD, 1'b1, 1'b0, V_Z);
`endif

        // drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge Clock);
        #1;
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
